// File: rtl/ascon_fsm_pkg.sv
// Shared types and round constants for the ASCON-128 control sequencer.
package ascon_pack;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_AD_WAIT,
        ST_AD_RUN,
        ST_PT_WAIT,
        ST_PT_RUN,
        ST_FINAL,
        ST_DONE
    } fsm_state_t;

    localparam int unsigned ROUNDS_A       = 12;
    localparam int unsigned ROUNDS_B       = 6;
    localparam logic [3:0]  PA_FIRST_ROUND = 4'd0;
    localparam logic [3:0]  PB_FIRST_ROUND = 4'd6;
    localparam logic [3:0]  LAST_ROUND     = 4'd11;

    // The final plaintext block doubles as the first finalization round.
    function automatic logic [3:0] block_first_round(input logic final_block);
        return final_block ? PA_FIRST_ROUND : PB_FIRST_ROUND;
    endfunction

endpackage

// File: rtl/ascon_fsm_if.sv
// Block-source handshake and datapath control bundle driven by ascon_fsm.
interface ascon_fsm_if;

    logic       start_i;
    logic [3:0] ad_blocks_i;
    logic [3:0] pt_blocks_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       select_o;
    logic       enable_state_o;
    logic       xor_data_begin_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       xor_ext_end_o;
    logic       enable_cipher_o;
    logic       enable_tag_o;
    logic [3:0] round_o;
    logic       cipher_valid_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        input  start_i, ad_blocks_i, pt_blocks_i, data_valid_i,
        output data_ready_o, select_o, enable_state_o,
               xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_ext_end_o,
               enable_cipher_o, enable_tag_o, round_o, cipher_valid_o,
               busy_o, done_o
    );

    modport slave (
        output start_i, ad_blocks_i, pt_blocks_i, data_valid_i,
        input  data_ready_o, select_o, enable_state_o,
               xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_ext_end_o,
               enable_cipher_o, enable_tag_o, round_o, cipher_valid_o,
               busy_o, done_o
    );

endinterface

// File: rtl/ascon_fsm_round_counter.sv
// 4-bit permutation round index with load, increment and last-round flag.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       inc_i,
    output logic [3:0] round_o,
    output logic       last_o
);

    logic [3:0] count;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count <= '0;
        end else if (load_i) begin
            count <= load_value_i;
        end else if (inc_i) begin
            count <= count + 4'd1;
        end
    end

    assign round_o = count;
    assign last_o  = (count == LAST_ROUND);

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 sequencer: init, AD absorption, encryption and finalization control.
module ascon_fsm
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    ascon_fsm_if.master ctrl
);

    fsm_state_t state;
    logic [3:0] ad_cnt;
    logic [3:0] pt_cnt;
    logic       cipher_valid_q;

    logic [3:0] rnd;
    logic       last;
    logic       cnt_load;
    logic       cnt_inc;
    logic [3:0] cnt_value;

    logic ready;
    logic hs;
    logic pt_final;

    assign ready    = (state == ST_AD_WAIT) || (state == ST_PT_WAIT);
    assign hs       = ready && ctrl.data_valid_i;
    assign pt_final = (pt_cnt == 4'd1);

    round_counter u_round_counter (
        .clock_i      (clock_i),
        .resetb_i     (resetb_i),
        .load_i       (cnt_load),
        .load_value_i (cnt_value),
        .inc_i        (cnt_inc),
        .round_o      (rnd),
        .last_o       (last)
    );

    // The first round of the next block is loaded as the current one ends,
    // so the handshake cycle itself already presents it.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        cnt_value = PA_FIRST_ROUND;
        case (state)
            ST_IDLE: cnt_load = ctrl.start_i;
            ST_INIT: begin
                if (last) begin
                    cnt_load  = 1'b1;
                    cnt_value = (ad_cnt != 4'd0) ? PB_FIRST_ROUND : block_first_round(pt_final);
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_AD_WAIT: cnt_inc = hs;
            ST_AD_RUN: begin
                if (last) begin
                    cnt_load  = 1'b1;
                    cnt_value = (ad_cnt == 4'd1) ? block_first_round(pt_final) : PB_FIRST_ROUND;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_PT_WAIT: cnt_inc = hs;
            ST_PT_RUN: begin
                if (last) begin
                    cnt_load  = 1'b1;
                    cnt_value = block_first_round(pt_cnt == 4'd2);
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_FINAL: begin
                cnt_load = last;
                cnt_inc  = !last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state          <= ST_IDLE;
            ad_cnt         <= '0;
            pt_cnt         <= '0;
            cipher_valid_q <= 1'b0;
        end else begin
            cipher_valid_q <= (state == ST_PT_WAIT) && hs;
            case (state)
                ST_IDLE: begin
                    if (ctrl.start_i) begin
                        ad_cnt <= ctrl.ad_blocks_i;
                        pt_cnt <= (ctrl.pt_blocks_i == 4'd0) ? 4'd1 : ctrl.pt_blocks_i;
                        state  <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (last) state <= (ad_cnt != 4'd0) ? ST_AD_WAIT : ST_PT_WAIT;
                end
                ST_AD_WAIT: begin
                    if (hs) state <= ST_AD_RUN;
                end
                ST_AD_RUN: begin
                    if (last) begin
                        if (ad_cnt != 4'd0) ad_cnt <= ad_cnt - 4'd1;
                        state <= (ad_cnt == 4'd1) ? ST_PT_WAIT : ST_AD_WAIT;
                    end
                end
                ST_PT_WAIT: begin
                    if (hs) state <= pt_final ? ST_FINAL : ST_PT_RUN;
                end
                ST_PT_RUN: begin
                    if (last) begin
                        if (pt_cnt > 4'd1) pt_cnt <= pt_cnt - 4'd1;
                        state <= ST_PT_WAIT;
                    end
                end
                ST_FINAL: begin
                    if (last) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl.data_ready_o     = ready;
        ctrl.select_o         = (state == ST_INIT) && (rnd == PA_FIRST_ROUND);
        ctrl.enable_state_o   = (state == ST_INIT) || (state == ST_AD_RUN) ||
                                (state == ST_PT_RUN) || (state == ST_FINAL) || hs;
        ctrl.xor_data_begin_o = hs;
        ctrl.xor_key_begin_o  = (state == ST_PT_WAIT) && hs && pt_final;
        ctrl.xor_key_end_o    = ((state == ST_INIT) || (state == ST_FINAL)) && last;
        ctrl.xor_ext_end_o    = ((state == ST_INIT) && last && (ad_cnt == 4'd0)) ||
                                ((state == ST_AD_RUN) && last && (ad_cnt == 4'd1));
        ctrl.enable_cipher_o  = (state == ST_PT_WAIT) && hs;
        ctrl.enable_tag_o     = (state == ST_FINAL) && last;
        ctrl.round_o          = (state == ST_IDLE) ? 4'd0 : rnd;
        ctrl.cipher_valid_o   = cipher_valid_q;
        ctrl.busy_o           = (state != ST_IDLE);
        ctrl.done_o           = (state == ST_DONE);
    end

endmodule

// File: tb/tb_ascon_fsm.sv
// Self-checking bench for ascon_fsm: timeline model built from block schedules.
module tb_ascon_fsm;
    import ascon_pack::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascon_fsm_if bus ();

    ascon_fsm dut (
        .clock_i  (clk),
        .resetb_i (rst_n),
        .ctrl     (bus)
    );

    typedef struct packed {
        logic       ready;
        logic       sel;
        logic       en_st;
        logic       xdb;
        logic       xkb;
        logic       xke;
        logic       xee;
        logic       en_c;
        logic       en_t;
        logic [3:0] rnd;
        logic       cv;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        logic  start;
        logic  valid;
        outs_t exp;
    } step_t;

    typedef struct {
        int ad;
        int pt;
        int w;
        int done_cyc;
    } vec_t;

    step_t tl[$];
    logic  pend_cv;
    int    n_pass = 0;
    int    n_chk  = 0;

    function automatic outs_t dut_outs();
        outs_t o;
        o.ready = bus.data_ready_o;
        o.sel   = bus.select_o;
        o.en_st = bus.enable_state_o;
        o.xdb   = bus.xor_data_begin_o;
        o.xkb   = bus.xor_key_begin_o;
        o.xke   = bus.xor_key_end_o;
        o.xee   = bus.xor_ext_end_o;
        o.en_c  = bus.enable_cipher_o;
        o.en_t  = bus.enable_tag_o;
        o.rnd   = bus.round_o;
        o.cv    = bus.cipher_valid_o;
        o.busy  = bus.busy_o;
        o.done  = bus.done_o;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t got, input outs_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b required=%b", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d required=%0d", name, got, exp);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // cipher_valid follows every cipher-enable cycle by exactly one cycle.
    task automatic push(input logic start, input logic valid, input outs_t e);
        e.cv    = pend_cv;
        pend_cv = e.en_c;
        tl.push_back('{start, valid, e});
    endtask

    task automatic build(input int ad, input int pt, input int w_first, input bit rand_w,
                         output int total_w);
        outs_t e;
        int ptn;
        int w;
        bit fin;
        tl.delete();
        pend_cv = 1'b0;
        total_w = 0;
        ptn = (pt == 0) ? 1 : pt;
        e = '0;
        push(1'b1, rbit(), e);
        for (int r = 0; r < int'(ROUNDS_A); r++) begin
            e = '0; e.busy = 1; e.en_st = 1; e.rnd = 4'(r);
            e.sel = (r == 0); e.xke = (r == 11); e.xee = (r == 11 && ad == 0);
            push(rbit(), rbit(), e);
        end
        for (int b = 0; b < ad; b++) begin
            w = rand_w ? int'($urandom_range(0, 2)) : ((b == 0) ? w_first : 0);
            total_w += w;
            for (int k = 0; k < w; k++) begin
                e = '0; e.busy = 1; e.ready = 1; e.rnd = 4'd6;
                push(rbit(), 1'b0, e);
            end
            e = '0; e.busy = 1; e.ready = 1; e.en_st = 1; e.xdb = 1; e.rnd = 4'd6;
            push(rbit(), 1'b1, e);
            for (int r = 7; r <= 11; r++) begin
                e = '0; e.busy = 1; e.en_st = 1; e.rnd = 4'(r);
                e.xee = (r == 11 && b == ad - 1);
                push((r == 8) ? 1'b1 : rbit(), rbit(), e);
            end
        end
        for (int p = 0; p < ptn; p++) begin
            fin = (p == ptn - 1);
            w = rand_w ? int'($urandom_range(0, 2)) : 0;
            total_w += w;
            for (int k = 0; k < w; k++) begin
                e = '0; e.busy = 1; e.ready = 1; e.rnd = fin ? 4'd0 : 4'd6;
                push(rbit(), 1'b0, e);
            end
            e = '0; e.busy = 1; e.ready = 1; e.en_st = 1; e.xdb = 1; e.en_c = 1;
            e.xkb = fin; e.rnd = fin ? 4'd0 : 4'd6;
            push(rbit(), 1'b1, e);
            for (int r = fin ? 1 : 7; r <= 11; r++) begin
                e = '0; e.busy = 1; e.en_st = 1; e.rnd = 4'(r);
                e.xke = fin && (r == 11); e.en_t = fin && (r == 11);
                push(rbit(), rbit(), e);
            end
        end
        e = '0; e.busy = 1; e.done = 1;
        push(rbit(), rbit(), e);
        for (int k = 0; k < 3; k++) begin
            e = '0;
            push(1'b0, rbit(), e);
        end
    endtask

    task automatic run(input string tag, input int ad, input int pt, input int w_first,
                       input bit rand_w, input int exp_done);
        int total_w;
        int done_at, cip, ext, tg, adhs, want_done;
        outs_t got;
        build(ad, pt, w_first, rand_w, total_w);
        done_at = -1; cip = 0; ext = 0; tg = 0; adhs = 0;
        for (int i = 0; i < tl.size(); i++) begin
            @(posedge clk);
            #1;
            bus.start_i      = tl[i].start;
            bus.data_valid_i = tl[i].valid;
            if (i == 0) begin
                bus.ad_blocks_i = 4'(ad);
                bus.pt_blocks_i = 4'(pt);
            end else begin
                bus.ad_blocks_i = 4'($urandom_range(0, 15));
                bus.pt_blocks_i = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            got = dut_outs();
            check_outs($sformatf("%s_cyc%0d", tag, i), got, tl[i].exp);
            if (got.done && done_at < 0) done_at = i;
            cip  += int'(got.cv);
            ext  += int'(got.xee);
            tg   += int'(got.en_t);
            adhs += int'(got.xdb && !got.en_c);
        end
        want_done = (exp_done >= 0) ? exp_done
                  : 12 + total_w + 6 * ad + 6 * (((pt == 0) ? 1 : pt) - 1) + 12 + 1;
        check_int({tag, "_done_cycle"}, done_at, want_done);
        check_int({tag, "_cipher_pulses"}, cip, (pt == 0) ? 1 : pt);
        check_int({tag, "_ext_pulses"}, ext, 1);
        check_int({tag, "_tag_pulses"}, tg, 1);
        check_int({tag, "_ad_handshakes"}, adhs, ad);
    endtask

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 2, 0, 37};
        vecs[1] = '{1, 2, 5, 42};
        vecs[2] = '{0, 1, 0, 25};
        vecs[3] = '{0, 0, 0, 25};
        vecs[4] = '{2, 1, 0, 37};
        vecs[5] = '{3, 4, 2, 63};
        vecs[6] = '{15, 15, 0, 199};

        bus.start_i = 1'b0; bus.data_valid_i = 1'b1;
        bus.ad_blocks_i = 4'd3; bus.pt_blocks_i = 4'd3;
        #12;
        check_outs("reset_outputs", dut_outs(), '0);
        bus.start_i = 1'b1;
        #10;
        check_outs("reset_ignores_start", dut_outs(), '0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("idle_after_reset", dut_outs(), '0);

        for (int v = 0; v < 7; v++)
            run($sformatf("vec%0d", v), vecs[v].ad, vecs[v].pt, vecs[v].w, 1'b0, vecs[v].done_cyc);

        // Reset during FINAL round 5, then a fresh full sequence.
        @(posedge clk);
        #1;
        bus.start_i = 1'b1; bus.ad_blocks_i = 4'd0; bus.pt_blocks_i = 4'd1; bus.data_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        check_int("final_round_before_reset", int'(bus.round_o), 5);
        check_int("final_busy_before_reset", int'(bus.busy_o), 1);
        rst_n = 1'b0;
        #1;
        check_outs("async_reset_outputs", dut_outs(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("idle_after_mid_reset", dut_outs(), '0);
        run("post_reset", 1, 2, 0, 1'b0, 37);

        for (int k = 0; k < 6; k++)
            run($sformatf("rand%0d", k), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                0, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ascon_fsm.md
# ascon_fsm

Control sequencer for the ASCON-128 encryption datapath. It sits directly upstream of the round-per-cycle permutation datapath and drives its mux select, state/cipher/tag enables, begin/end XOR strobes and 4-bit round index. It walks the datapath through initialization, associated-data absorption, plaintext encryption and finalization. It also runs a valid/ready handshake with the block source, which delivers already-padded 64-bit blocks.

## Interface
- No parameters.
- `clock_i` in 1: system clock, rising edge.
- `resetb_i` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start_i` in 1: begin an operation; sampled only in IDLE.
- `ad_blocks_i` in 4: number of AD blocks (0..15); latched on start.
- `pt_blocks_i` in 4: number of plaintext blocks (1..15; 0 is treated as 1); latched on start.
- `data_valid_i` in 1: source presents a block on the datapath data input.
- `data_ready_o` out 1: FSM accepts a block this cycle. A handshake occurs when `data_valid_i` and `data_ready_o` are both high.
- `select_o` out 1: datapath mux; 1 loads the external initial state.
- `enable_state_o` out 1: state register enable.
- `xor_data_begin_o`, `xor_key_begin_o` out 1 each: begin-XOR strobes.
- `xor_key_end_o`, `xor_ext_end_o` out 1 each: end-XOR strobes (key XOR, domain separation).
- `enable_cipher_o` out 1: cipher register enable.
- `enable_tag_o` out 1: tag register enable.
- `round_o` out 4: round-constant index.
- `cipher_valid_o` out 1: cipher register holds a new block.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the tag is valid.

## Operation
- States: IDLE, INIT, AD_WAIT, AD_RUN, PT_WAIT, PT_RUN, FINAL, DONE.
- Outputs are decoded from the state, round counter and handshake. Every output is 0 in IDLE and during reset.
- **IDLE**
  - On `start_i`, latch the block counts, clear the round counter and go to INIT.
- **INIT** (rounds 0..11, one per cycle)
  - `enable_state_o`=1 throughout.
  - Round 0: `select_o`=1.
  - Round 11: `xor_key_end_o`=1; `xor_ext_end_o`=1 if `ad_blocks`==0.
  - Exit to AD_WAIT if `ad_blocks`>0, else PT_WAIT.
- **AD_WAIT**
  - `data_ready_o`=1.
  - Handshake cycle = first round 6: `xor_data_begin_o`=1 and `enable_state_o`=1; go to AD_RUN.
  - With no handshake, hold state; all strobes stay 0.
- **AD_RUN** (rounds 7..11)
  - On the last AD block, round 11 asserts `xor_ext_end_o`.
  - Decrement the AD count; go to AD_WAIT, or PT_WAIT when the count reaches 0.
- **PT_WAIT**, non-final block
  - `data_ready_o`=1.
  - Handshake asserts `xor_data_begin_o`, `enable_cipher_o` and `enable_state_o` with round 6; go to PT_RUN.
- **PT_RUN** (rounds 7..11)
  - Decrement the PT count, then return to PT_WAIT.
- **PT_WAIT**, final block (PT count==1)
  - Handshake additionally asserts `xor_key_begin_o`, with round 0; go to FINAL.
- **FINAL** (rounds 1..11)
  - Round 11 asserts `xor_key_end_o` and `enable_tag_o`; go to DONE.
- **DONE**
  - `done_o`=1 for one cycle, then IDLE.
- `cipher_valid_o` pulses for one cycle, the cycle after every handshake in PT_WAIT.
- Boundary conditions:
  - `start_i` is ignored outside IDLE.
  - `data_valid_i` is ignored when `data_ready_o`=0.
  - Block counters never wrap; the exit decision is made on the count value 1.
  - Reset asserted mid-operation returns to IDLE immediately, with all outputs 0.

## Timing
- The round counter is 4 bits.
  - INIT/FINAL span 0..11 (pa, 12 rounds); AD/PT blocks span 6..11 (pb, 6 rounds).
  - The counter loads the first round on entry and increments each cycle in RUN states.
- Zero-bubble handshake: the handshake cycle is itself the first permutation round.
- With `start_i` at cycle 0 and `data_valid_i` held high, the sequence is:
  - cycles 1–12: INIT;
  - per AD block: 6 cycles;
  - per non-final PT block: 6 cycles;
  - final PT block: 12 cycles;
  - then DONE.
- Example, `ad_blocks`=1 and `pt_blocks`=2:
  - AD handshake at cycle 13;
  - PT handshakes at cycles 19 and 25;
  - `enable_tag_o` at cycle 36;
  - `done_o` at cycle 37, with the tag valid from 37.
- Latency scales linearly with any wait cycles.

## Structure
- Shared package `ascon_pack` gains:
  - `typedef enum` for the FSM states;
  - constants `ROUNDS_A`=12, `ROUNDS_B`=6, `PB_FIRST_ROUND`=4'd6, `LAST_ROUND`=4'd11.
- Sub-module `round_counter`: 4-bit counter with load value, increment enable, and last-round flag output.
- A top-level ASCON wrapper instantiates `ascon_fsm` next to the permutation datapath.

## Test plan
- **Nominal sequence:** reset, then `start_i` with ad=1, pt=2, valid held high → handshakes at cycles 13/19/25; `round_o` sequences 0..11, 6..11, 6..11, 0..11; `done_o` only at cycle 37.
- **No AD:** ad=0, pt=1 → INIT round 11 asserts `xor_key_end_o` and `xor_ext_end_o` together; the single PT handshake asserts `xor_key_begin_o` with round 0.
- **Backpressure:** valid low for 5 cycles in AD_WAIT → `enable_state_o`=0 and all strobes 0 during the wait; done is delayed by exactly 5 cycles.
- **Ignored inputs:** `start_i` pulsed mid-AD_RUN → no effect. `pt_blocks_i`=0 → behaves as pt=1. `cipher_valid_o` pulses once per PT handshake.
- **Reset mid-FINAL:** `resetb_i` low at round 5 → all outputs 0 asynchronously; a fresh start runs a full sequence.
- **Maximum counts:** ad=15, pt=15 → exactly 15 pulses of `xor_ext_end_o`-qualified AD blocks (1 ext pulse), 15 cipher pulses, and 1 `enable_tag_o` pulse.
